chnl_rx_buf: RTL and testbench
==============================

CHNL_RX_BUF -- requirements
Module: chnl_rx_buf

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 32, PCIe data width (32, 64 or 128); NW = C_PCI_DATA_WIDTH/32.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >= 2); AW = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports o_val output 1, o_rdy input 1, o_data output C_PCI_DATA_WIDTH  downstream valid/ready stream.
REQ-006 SHALL have port o_last  output  1  beat is last of its transaction.
REQ-007 SHALL have port o_nwords  output  clog2(NW)+1  count of valid 32-bit words in beat (1..NW), LSB-aligned.
REQ-008 SHALL have ports CHNL_RX_CLK out 1, CHNL_RX in 1, CHNL_RX_ACK out 1, CHNL_RX_LAST in 1, CHNL_RX_LEN in 32, CHNL_RX_OFF in 31, CHNL_RX_DATA in C_PCI_DATA_WIDTH, CHNL_RX_DATA_VALID in 1, CHNL_RX_DATA_REN out 1  RIFFA receive channel.
REQ-009 SHALL have port fifo_level  output  AW+1  current FIFO occupancy.
REQ-010 SHALL have port xfer_cnt  output  32  completed transactions, wraps 0xFFFFFFFF->0.
REQ-011 SHALL have port busy  output  1  high in S_RECV or FIFO non-empty.

Function
REQ-012 SHALL drive CHNL_RX_CLK = clk combinationally.
REQ-013 SHALL implement states S_IDLE, S_RECV.
REQ-014 In S_IDLE with CHNL_RX=1 SHALL latch beats_left = ceil(LEN/NW) (33-bit arithmetic, no overflow at LEN=0xFFFFFFFF), tail = LEN mod NW (0 means NW), and enter S_RECV next cycle; CHNL_RX_OFF, CHNL_RX_LAST ignored.
REQ-015 In S_RECV SHALL hold CHNL_RX_ACK=1; ACK=0 in S_IDLE.
REQ-016 SHALL drive CHNL_RX_DATA_REN = (state==S_RECV) && beats_left!=0 && !full, using registered full only (no same-cycle pop bypass).
REQ-017 A beat SHALL be accepted when REN && CHNL_RX_DATA_VALID; it is written to FIFO with last=(beats_left==1), nwords=(last ? tail : NW); beats_left decrements.
REQ-018 In S_RECV with beats_left==0 SHALL return to S_IDLE next cycle and increment xfer_cnt; LEN=0 gives one S_RECV cycle, no FIFO write, xfer_cnt+1.
REQ-019 FIFO SHALL be first-word-fall-through: o_val = !empty; o_data/o_last/o_nwords show head entry; pop on o_val && o_rdy.
REQ-020 Simultaneous push and pop SHALL leave fifo_level unchanged; push only when !full, pop only when !empty.
REQ-021 Input-to-output latency SHALL be 1 cycle (accept in cycle N, o_val high in N+1 when FIFO was empty).
REQ-022 o_data/o_last/o_nwords SHALL hold stable while o_val && !o_rdy.
REQ-023 Back-to-back transactions SHALL be accepted while prior data drains; last flags keep boundaries.

Reset
REQ-024 On rst: state=S_IDLE, beats_left=0, FIFO empty, xfer_cnt=0; outputs o_val=0, o_last=0, ACK=0, REN=0, fifo_level=0, busy=0.
REQ-025 rst mid-transaction SHALL discard FIFO contents and remaining beats; no partial recovery.
REQ-026 FIFO data RAM need not be reset.

Structure
REQ-027 Shared package SHALL hold state encodings S_IDLE/S_RECV and the RIFFA word width constant 32.
REQ-028 FIFO SHALL be a separate sub-module chnl_fifo (WIDTH, DEPTH params; i_val/i_rdy, o_val/o_rdy, level); control FSM in chnl_rx_buf.

Verification (C_PCI_DATA_WIDTH=64, DEPTH=4)
REQ-029 LEN=6, VALID always, o_rdy=1 -> 3 beats, third o_last=1 o_nwords=2, xfer_cnt=1.
REQ-030 LEN=5 -> ceil=3 beats, last o_nwords=1; LEN=0 -> ACK one cycle, no o_val, xfer_cnt+1.
REQ-031 LEN=20, o_rdy=0 -> REN drops after 4 accepts, fifo_level=4; release o_rdy -> all 10 beats in order, no loss/dup.
REQ-032 Random VALID/o_rdy, two transactions LEN=7 then LEN=4 back-to-back -> o_last on beats 4 and 6, data matches scoreboard.
REQ-033 rst asserted after 2 of 5 beats -> next cycle ACK=0, REN=0, o_val=0, fifo_level=0; new LEN=2 then completes normally.

Source files
------------

// File: rtl/chnl_rx_buf_pkg.sv
// Shared definitions for the RIFFA receive-channel buffer.
// Holds the control FSM encoding and the RIFFA word width.
package chnl_rx_buf_pkg;

  localparam int RIFFA_WORD_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/chnl_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// The head entry is visible on o_data whenever o_val is high.
module chnl_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_val,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_val,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign i_rdy  = (level != (AW+1)'(DEPTH));
  assign o_val  = (level != '0);
  assign push   = i_val && i_rdy;
  assign pop    = o_val && o_rdy;
  assign o_data = mem[rd_ptr];

  // Storage is deliberately left without reset; level gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/chnl_rx_buf.sv
// RIFFA receive channel front end: counts beats of each transaction,
// tags the final beat and its valid word count, and buffers into a FIFO.
module chnl_rx_buf
  import chnl_rx_buf_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int DEPTH            = 16,
  localparam int NW     = C_PCI_DATA_WIDTH / RIFFA_WORD_W,
  localparam int LOG2NW = $clog2(NW),
  localparam int NWW    = $clog2(NW) + 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int EW     = C_PCI_DATA_WIDTH + NWW + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [C_PCI_DATA_WIDTH-1:0] o_data,
  output logic                        o_last,
  output logic [NWW-1:0]              o_nwords,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic [AW:0]                 fifo_level,
  output logic [31:0]                 xfer_cnt,
  output logic                        busy
);

  state_t          state;
  state_t          state_next;
  logic [31:0]     beats_left;
  logic [NWW-1:0]  tail;
  logic [32:0]     len_ext;
  logic [31:0]     beats_calc;
  logic [NWW-1:0]  tail_calc;
  logic            fifo_rdy;
  logic            accept;
  logic            last_beat;
  logic [NWW-1:0]  beat_nwords;
  logic            xfer_done;
  logic            head_last;
  logic            unused_inputs;

  assign CHNL_RX_CLK   = clk;
  assign unused_inputs = ^{CHNL_RX_OFF, CHNL_RX_LAST};

  // Widened by one bit so the round-up cannot overflow at LEN=0xFFFFFFFF.
  assign len_ext    = {1'b0, CHNL_RX_LEN} + 33'(NW - 1);
  assign beats_calc = 32'(len_ext >> LOG2NW);
  assign tail_calc  = ((CHNL_RX_LEN & 32'(NW - 1)) == 32'd0) ? NWW'(NW)
                                                             : NWW'(CHNL_RX_LEN & 32'(NW - 1));

  assign accept      = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
  assign last_beat   = (beats_left == 32'd1);
  assign beat_nwords = last_beat ? tail : NWW'(NW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    CHNL_RX_ACK      = 1'b0;
    CHNL_RX_DATA_REN = 1'b0;
    xfer_done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (CHNL_RX) state_next = S_IDLE == S_IDLE ? S_RECV : S_IDLE;
      end
      S_RECV: begin
        CHNL_RX_ACK      = 1'b1;
        CHNL_RX_DATA_REN = (beats_left != '0) && fifo_rdy;
        if (beats_left == '0) begin
          state_next = S_IDLE;
          xfer_done  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_left <= '0;
      tail       <= NWW'(NW);
      xfer_cnt   <= '0;
    end else begin
      if (state == S_IDLE && CHNL_RX) begin
        beats_left <= beats_calc;
        tail       <= tail_calc;
      end else if (accept) begin
        beats_left <= beats_left - 1'b1;
      end
      if (xfer_done) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  chnl_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_val  (accept),
    .i_rdy  (fifo_rdy),
    .i_data ({last_beat, beat_nwords, CHNL_RX_DATA}),
    .o_val  (o_val),
    .o_rdy  (o_rdy),
    .o_data ({head_last, o_nwords, o_data}),
    .level  (fifo_level)
  );

  // Head contents are unreset RAM, so the last flag is qualified by o_val.
  assign o_last = o_val && head_last;
  assign busy   = (state == S_RECV) || o_val;

endmodule

// File: tb/tb_chnl_rx_buf.sv
// Randomized bench for chnl_rx_buf (64-bit data, 4-entry FIFO) with a
// transaction-level scoreboard of expected beats and FIFO occupancy.
module tb_chnl_rx_buf;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int NW    = DW / 32;

  typedef struct packed {
    logic          last;
    logic [1:0]    nwords;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          o_val;
  logic          o_rdy;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [1:0]    o_nwords;
  logic          rx_clk;
  logic          chnl_rx;
  logic          rx_ack;
  logic          rx_last;
  logic [31:0]   rx_len;
  logic [30:0]   rx_off;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ren;
  logic [2:0]    fifo_level;
  logic [31:0]   xfer_cnt;
  logic          busy;

  int    n_checks   = 0;
  int    n_pass     = 0;
  int    rdy_mode   = 0;
  int    lvl_model  = 0;
  int    model_xfer = 0;
  int    acc_cnt    = 0;
  bit    abort      = 0;
  bit    hold_valid = 0;
  beat_t hold_beat;
  beat_t exp_q[$];

  chnl_rx_buf #(
    .C_PCI_DATA_WIDTH (DW),
    .DEPTH            (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .o_val              (o_val),
    .o_rdy              (o_rdy),
    .o_data             (o_data),
    .o_last             (o_last),
    .o_nwords           (o_nwords),
    .CHNL_RX_CLK        (rx_clk),
    .CHNL_RX            (chnl_rx),
    .CHNL_RX_ACK        (rx_ack),
    .CHNL_RX_LAST       (rx_last),
    .CHNL_RX_LEN        (rx_len),
    .CHNL_RX_OFF        (rx_off),
    .CHNL_RX_DATA       (rx_data),
    .CHNL_RX_DATA_VALID (rx_valid),
    .CHNL_RX_DATA_REN   (rx_ren),
    .fifo_level         (fifo_level),
    .xfer_cnt           (xfer_cnt),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = stalled, other = random.
  initial begin
    o_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       o_rdy = 1'b1;
        1:       o_rdy = 1'b0;
        default: o_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: expected beats in order and occupancy = pushes - pops.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      lvl_model  = 0;
      hold_valid = 0;
    end else begin
      checkOutput("fifo_level", fifo_level, lvl_model);
      checkOutput("o_val", o_val, lvl_model != 0);
      checkOutput("busy", busy, rx_ack || (lvl_model != 0));
      if (lvl_model == DEPTH) checkOutput("ren_when_full", rx_ren, 0);
      if (hold_valid) begin
        checkOutput("hold_data", o_data, hold_beat.data);
        checkOutput("hold_last", o_last, hold_beat.last);
        checkOutput("hold_nwords", o_nwords, hold_beat.nwords);
      end
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_data", o_data, b.data);
          checkOutput("beat_last", o_last, b.last);
          checkOutput("beat_nwords", o_nwords, b.nwords);
        end
      end
      hold_valid = o_val && !o_rdy;
      hold_beat  = '{last: o_last, nwords: o_nwords, data: o_data};
      lvl_model  = lvl_model + int'(rx_ren && rx_valid) - int'(o_val && o_rdy);
    end
  end

  // Offers one transaction of len words; expected beats come from LEN alone.
  task automatic applyStimulus(input int len, input bit rand_valid, output int ack_cycles);
    longint        nb;
    int            tail;
    int            idx;
    int            cyc;
    bit            seen_ack;
    bit            done;
    logic [DW-1:0] dq[$];
    nb   = (longint'(len) + NW - 1) / NW;
    tail = (len % NW == 0) ? NW : len % NW;
    for (longint i = 0; i < nb; i++) begin
      beat_t b;
      b.data   = {$urandom, $urandom};
      b.last   = (i == nb - 1);
      b.nwords = b.last ? 2'(tail) : 2'(NW);
      dq.push_back(b.data);
      exp_q.push_back(b);
    end
    acc_cnt    = 0;
    ack_cycles = 0;
    idx        = 0;
    cyc        = 0;
    seen_ack   = 0;
    done       = 0;
    chnl_rx    = 1'b1;
    rx_len     = 32'(len);
    rx_off     = 31'($urandom);
    while (!done && !abort && cyc < 3000) begin
      rx_data  = (idx < nb) ? dq[idx] : '0;
      rx_valid = (idx < nb) && (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (rx_ren && rx_valid) begin
        idx++;
        acc_cnt++;
      end
      if (rx_ack) begin
        seen_ack = 1;
        ack_cycles++;
      end else if (seen_ack) begin
        done = 1;
      end
      @(posedge clk);
      #1;
      if (seen_ack) chnl_rx = 1'b0;
      cyc++;
    end
    chnl_rx  = 1'b0;
    rx_valid = 1'b0;
    if (!abort) begin
      if (!done) checkOutput("txn_timeout", 0, 1);
      checkOutput("beats_accepted", idx, nb);
      model_xfer++;
      checkOutput("xfer_cnt", xfer_cnt, model_xfer);
    end
  endtask

  task automatic drainOutput();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ack_n;
    int cyc;
    rst      = 1'b1;
    chnl_rx  = 1'b0;
    rx_last  = 1'b1;
    rx_len   = '0;
    rx_off   = '0;
    rx_data  = '0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_o_val", o_val, 0);
    checkOutput("rst_o_last", o_last, 0);
    checkOutput("rst_ack", rx_ack, 0);
    checkOutput("rst_ren", rx_ren, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_xfer", xfer_cnt, 0);
    checkOutput("rx_clk_low", rx_clk, 0);
    @(posedge clk);
    #1;
    checkOutput("rx_clk_high", rx_clk, 1);
    rst = 1'b0;

    $display("[TB] LEN=6, ready always");
    rdy_mode = 0;
    applyStimulus(6, 0, ack_n);
    checkOutput("len6_ack_cycles", ack_n, 4);
    drainOutput();

    $display("[TB] LEN=5 then LEN=0");
    applyStimulus(5, 0, ack_n);
    drainOutput();
    applyStimulus(0, 0, ack_n);
    checkOutput("len0_ack_cycles", ack_n, 1);
    drainOutput();

    $display("[TB] LEN=20 with downstream stalled");
    rdy_mode = 1;
    fork
      applyStimulus(20, 0, ack_n);
      begin
        repeat (12) @(negedge clk);
        checkOutput("stall_accepts", acc_cnt, 4);
        checkOutput("stall_level", fifo_level, 4);
        checkOutput("stall_ren", rx_ren, 0);
        checkOutput("stall_o_val", o_val, 1);
        rdy_mode = 0;
      end
    join
    drainOutput();

    $display("[TB] LEN=7 then LEN=4, random valid/ready");
    rdy_mode = 2;
    applyStimulus(7, 1, ack_n);
    applyStimulus(4, 1, ack_n);
    drainOutput();

    $display("[TB] reset after 2 of 5 beats");
    rdy_mode = 0;
    fork
      applyStimulus(10, 0, ack_n);
      begin
        cyc = 0;
        while (acc_cnt < 2 && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        checkOutput("pre_reset_accepts", acc_cnt, 2);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        abort = 1;
        exp_q.delete();
        model_xfer = 0;
        @(negedge clk);
        checkOutput("mid_rst_ack", rx_ack, 0);
        checkOutput("mid_rst_ren", rx_ren, 0);
        checkOutput("mid_rst_o_val", o_val, 0);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_xfer", xfer_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    abort = 0;
    @(posedge clk);
    #1;
    applyStimulus(2, 0, ack_n);
    drainOutput();

    $display("[TB] random transactions");
    for (int t = 0; t < 8; t++) begin
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      applyStimulus(int'($urandom_range(0, 13)), 1'($urandom_range(0, 1)), ack_n);
    end
    rdy_mode = 2;
    drainOutput();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
